// File: rtl/maxpool_2x2_param_2.sv
// Streaming 2x2/stride-2 signed max-pool over a raster-order frame, one pixel per cycle.
// Optional MAXPOOL_FRAME_DONE_EN adds a frame_done pulse on the last pooled pixel of a frame.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module maxpool_2x2_param_2 #(
  parameter int unsigned DATA_WIDTH   = `DATA_WIDTH,
  parameter int unsigned ROW_WIDTH    = 24,
  parameter int unsigned FRAME_HEIGHT = 24,
  parameter int unsigned COL_BITWIDTH = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data
`ifdef MAXPOOL_FRAME_DONE_EN
  ,
  output logic                         frame_done
`endif
);

  localparam int unsigned LB_DEPTH = ROW_WIDTH / 2;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [COL_BITWIDTH-1:0] COL_LAST = COL_BITWIDTH'(ROW_WIDTH - 1);
  localparam logic [COL_BITWIDTH-1:0] ROW_LAST = COL_BITWIDTH'(FRAME_HEIGHT - 1);

  typedef enum logic {EVEN_ROW = 1'b0, ODD_ROW = 1'b1} row_state_t;

  row_state_t                    state, state_eff, state_next;
  logic [COL_BITWIDTH-1:0]       col, col_eff, col_next;
  logic [COL_BITWIDTH-1:0]       row, row_eff, row_next;
  logic signed [DATA_WIDTH-1:0]  h_reg, h_next;
  logic signed [DATA_WIDTH-1:0]  hmax, lbuf_rd, pool;
  logic signed [DATA_WIDTH-1:0]  lbuf [LB_DEPTH];
  logic [LB_AW-1:0]              lb_idx;
  logic                          col_wrap, row_wrap, emit, lb_we;

  // start overrides the position so the same-cycle pixel lands at row 0, col 0
  always_comb begin
    state_eff  = start ? EVEN_ROW : state;
    col_eff    = start ? '0 : col;
    row_eff    = start ? '0 : row;
    h_next     = start ? '0 : h_reg;
    col_wrap   = (col_eff == COL_LAST);
    row_wrap   = (row_eff == ROW_LAST);
    state_next = state_eff;
    col_next   = col_eff;
    row_next   = row_eff;
    lb_idx     = LB_AW'(col_eff >> 1);
    lbuf_rd    = lbuf[lb_idx];
    hmax       = (h_reg > in_data) ? h_reg : in_data;
    pool       = (lbuf_rd > hmax) ? lbuf_rd : hmax;
    emit       = in_valid && (state_eff == ODD_ROW) && col_eff[0];
    lb_we      = in_valid && (state_eff == EVEN_ROW) && col_eff[0];

    if (in_valid) begin
      if (!col_eff[0]) h_next = in_data;
      if (col_wrap) begin
        col_next   = '0;
        state_next = (state_eff == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
        row_next   = row_wrap ? '0 : row_eff + COL_BITWIDTH'(1);
      end else begin
        col_next = col_eff + COL_BITWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= EVEN_ROW;
      col       <= '0;
      row       <= '0;
      h_reg     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_next;
      col       <= col_next;
      row       <= row_next;
      h_reg     <= h_next;
      out_valid <= emit;
      if (emit) out_data <= pool;
    end
  end

  // Line buffer holds the even-row horizontal maxima; contents need no reset
  always_ff @(posedge clock) begin
    if (lb_we) lbuf[lb_idx] <= hmax;
  end

`ifdef MAXPOOL_FRAME_DONE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= emit && row_wrap && col_wrap;
  end
`endif

endmodule

// File: doc/maxpool_2x2_param_2.md
MAXPOOL_2X2_PARAM_2 -- requirements
Module: maxpool_2x2_param_2

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, `DATA_WIDTH (16), pixel width.
- ROW_WIDTH, 24, input row length in pixels; even.
- FRAME_HEIGHT, 24, input rows per frame; even.
- COL_BITWIDTH, 5, column/row counter width; >= clog2(max(ROW_WIDTH, FRAME_HEIGHT)).
REQ-003 Ports (name, direction, width, meaning), one per line:
- clock, in, 1, rising-edge clock.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, synchronous frame restart pulse.
- in_valid, in, 1, in_data carries a valid pixel this cycle.
- in_data, in, DATA_WIDTH signed, ReLU-stage output pixel, raster order.
- out_valid, out, 1, one-cycle pulse marking a valid pooled pixel.
- out_data, out, DATA_WIDTH signed, 2x2 maximum.
- frame_done, out, 1, present only with MAXPOOL_FRAME_DONE_EN (REQ-018).

Function
REQ-004 Input: one pixel per cycle with in_valid=1, row-major, ROW_WIDTH per row, FRAME_HEIGHT rows per frame; the block has no backpressure.
REQ-005 col counter SHALL advance 0..ROW_WIDTH-1 on each in_valid; it wraps to 0 after ROW_WIDTH-1, and the row counter then advances.
REQ-006 row counter SHALL wrap 0 after FRAME_HEIGHT-1 on the last pixel of a frame.
REQ-007 Counters and all registers SHALL hold when in_valid=0; gaps of any length are legal.
REQ-008 Row FSM SHALL have two states: EVEN_ROW (row[0]=0) and ODD_ROW (row[0]=1), toggling on every column wrap.
REQ-009 Even column: in_data SHALL be captured into h_reg.
REQ-010 Odd column: hmax = signed max(h_reg, in_data).
REQ-011 EVEN_ROW, odd column: hmax SHALL be written to line buffer entry col>>1 (ROW_WIDTH/2 entries of DATA_WIDTH).
REQ-012 ODD_ROW, odd column: out_data SHALL be registered as signed max(lbuf[col>>1], hmax), with out_valid=1 on the next clock edge (latency 1 cycle); otherwise out_valid=0.
REQ-013 out_data SHALL hold its last value while out_valid=0.
REQ-014 Ties SHALL be resolved to the equal value; comparisons are two's-complement signed.
REQ-015 Output count SHALL be (ROW_WIDTH/2)*(FRAME_HEIGHT/2) per frame.
REQ-016 start=1 SHALL clear col, row, h_reg and the FSM to EVEN_ROW; when in_valid=1 in the same cycle, that pixel is processed as row 0, col 0 of the new frame; any pending partial window is discarded; out_valid for a pixel accepted in the prior cycle still issues.

Reset
REQ-017 reset=1 SHALL asynchronously force col=0, row=0, FSM=EVEN_ROW, h_reg=0, out_valid=0, out_data=0 and frame_done=0; line buffer contents need not be reset; reset mid-frame discards the partial frame.

Configuration
REQ-018 Macro MAXPOOL_FRAME_DONE_EN:
- Defined: frame_done SHALL pulse high for one cycle, coincident with the out_valid of the final pooled pixel of each frame.
- Undefined: the frame_done port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-019 Directed scenarios, ROW_WIDTH=4, FRAME_HEIGHT=2:
- Frame rows [1,5,2,3] / [4,0,7,6], in_valid continuous -> out_valid pulses 1 cycle after pixels 6 and 8; out_data = 5 then 7.
- Negative inputs rows [-3,-1,-8,-2] / [-5,-4,-9,-7] -> out_data = -1 then -2.
- Same frame with in_valid low for 3 cycles after every pixel -> identical outputs; out_valid width is exactly 1 cycle.
- reset asserted after pixel 5, then a full new frame [9,9,9,9] / [9,9,9,9] -> no output before the new frame; outputs 9, 9.
- start with in_valid=1 on pixel 3 of a frame, followed by 7 more pixels forming [2,1,0,0] / [0,0,3,8] -> outputs 2, 8.
- MAXPOOL_FRAME_DONE_EN defined, two back-to-back frames -> frame_done high exactly with the 2nd and 4th out_valid; undefined -> port absent and the design compiles.
